// File: rtl/minicpu_pkg.sv
// Shared definitions for the mini CPU: operand source encoding, load strobe
// bit positions and the common datapath width.
package minicpu_pkg;

    localparam int WIDTH = 4;

    typedef enum logic [1:0] {
        SRC_A    = 2'b00,
        SRC_B    = 2'b01,
        SRC_IN   = 2'b10,
        SRC_ZERO = 2'b11
    } src_sel_e;

    localparam int LD_A   = 0;
    localparam int LD_B   = 1;
    localparam int LD_OUT = 2;
    localparam int LD_PC  = 3;

    localparam int LOAD_BITS = 4;
    // A, B and OUT share one register template; their strobes are bits 0..2.
    localparam int NUM_DATA_REGS = 3;

endpackage

// File: rtl/en_reg.sv
// Generic WIDTH-bit register with synchronous active-high reset and load enable.
module en_reg #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] q_next;

    always_comb begin
        q_next = q_reg;
        if (en) begin
            q_next = d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_reg <= '0;
        end else begin
            q_reg <= q_next;
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/alu_regfile.sv
// Register and sequencing stage around the 4-bit ALU: A/B/OUT registers, PC,
// carry flag and the ALU ain operand mux. All state advances only on step edges.
module alu_regfile #(
    parameter int WIDTH = minicpu_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             step,
    input  logic [1:0]       sel,
    input  logic [3:0]       load,
    input  logic [WIDTH-1:0] in_port,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_c,
    output logic [WIDTH-1:0] alu_ain,
    output logic [WIDTH-1:0] reg_a,
    output logic [WIDTH-1:0] reg_b,
    output logic [WIDTH-1:0] out_port,
    output logic [WIDTH-1:0] pc,
    output logic             c_flag
);

    import minicpu_pkg::*;

    src_sel_e         sel_e;
    logic [WIDTH-1:0] data_q [NUM_DATA_REGS];

    logic [WIDTH-1:0] pc_reg;
    logic [WIDTH-1:0] pc_next;
    logic             c_flag_reg;
    logic             c_flag_next;

    // Register slot index equals its load strobe bit (LD_A/LD_B/LD_OUT).
    generate
        for (genvar gi = 0; gi < NUM_DATA_REGS; gi++) begin : g_data_reg
            en_reg #(
                .WIDTH (WIDTH)
            ) u_reg (
                .clk (clk),
                .rst (rst),
                .en  (step & load[gi]),
                .d   (alu_out),
                .q   (data_q[gi])
            );
        end
    endgenerate

    assign reg_a    = data_q[LD_A];
    assign reg_b    = data_q[LD_B];
    assign out_port = data_q[LD_OUT];

    assign sel_e = src_sel_e'(sel);

    always_comb begin
        alu_ain = '0;
        case (sel_e)
            SRC_A:    alu_ain = reg_a;
            SRC_B:    alu_ain = reg_b;
            SRC_IN:   alu_ain = in_port;
            SRC_ZERO: alu_ain = '0;
            default:  alu_ain = '0;
        endcase
    end

    // Jump takes priority over the sequential increment; the increment wraps silently.
    always_comb begin
        pc_next     = pc_reg;
        c_flag_next = c_flag_reg;
        if (step) begin
            c_flag_next = alu_c;
            if (load[LD_PC]) begin
                pc_next = alu_out;
            end else begin
                pc_next = pc_reg + WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_reg     <= '0;
            c_flag_reg <= 1'b0;
        end else begin
            pc_reg     <= pc_next;
            c_flag_reg <= c_flag_next;
        end
    end

    assign pc     = pc_reg;
    assign c_flag = c_flag_reg;

endmodule
